avg8_seq_ctrl: RTL and testbench

Time-multiplexed controller for the 8-input averaging datapath. It replaces the 7-adder tree and 3-shifter chain with one shared 32-bit accumulator-adder and one shared shifter. Samples arrive serially over a valid/ready handshake, are summed over NUM cycles, and the sum is shifted right by sa SHIFTS times. It then returns a 16-bit avg with a one-cycle avg_valid pulse. It sits between the sample source and the consumer of avg, and is started by a start pulse.

---
 rtl/avg8_seq_ctrl.sv | 125 ++++++++++++
 tb/tb_avg8_seq_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/avg8_seq_ctrl.sv
// avg8_seq_ctrl: serial 8-sample averager with one shared accumulator and shifter.
// Optional macro AVG_SAT_EN: saturate avg instead of truncating the final sum.
`default_nettype none

module avg8_seq_ctrl #(
  parameter int DATAW  = 16,
  parameter int ACCW   = 32,
  parameter int NUM    = 8,
  parameter int SHIFTS = 3
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             start,
  input  logic [7:0]       sa,
  input  logic             in_valid,
  input  logic [DATAW-1:0] in_data,
  output logic             in_ready,
  output logic             busy,
  output logic [DATAW-1:0] avg,
  output logic             avg_valid
);

  localparam int CNTW = $clog2(NUM) + 1;
  localparam int SHW  = $clog2(SHIFTS) + 1;
  localparam logic [8:0] ACCW_L = 9'(ACCW);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t            state_q;
  logic [ACCW-1:0]   acc_q;
  logic [CNTW-1:0]   cnt_q;
  logic [SHW-1:0]    sh_cnt_q;
  logic [7:0]        sa_q;

  logic [ACCW-1:0]   acc_shift_d;
  logic [ACCW-1:0]   acc_sum_d;
  logic [DATAW-1:0]  avg_d;

  // Shift amounts at or beyond the accumulator width flush it to zero.
  always_comb begin
    acc_shift_d = '0;
    if ({1'b0, sa_q} < ACCW_L) begin
      acc_shift_d = acc_q >> sa_q;
    end
  end

  assign acc_sum_d = acc_q + {{(ACCW-DATAW){1'b0}}, in_data};

`ifdef AVG_SAT_EN
  always_comb begin
    avg_d = acc_shift_d[DATAW-1:0];
    if (|acc_shift_d[ACCW-1:DATAW]) begin
      avg_d = {DATAW{1'b1}};
    end
  end
`else
  logic unused_acc_hi;
  assign unused_acc_hi = ^acc_shift_d[ACCW-1:DATAW];
  always_comb begin
    avg_d = acc_shift_d[DATAW-1:0];
  end
`endif

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      sh_cnt_q  <= '0;
      sa_q      <= '0;
      avg       <= '0;
      avg_valid <= 1'b0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      avg_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            sa_q     <= sa;
            acc_q    <= '0;
            cnt_q    <= '0;
            state_q  <= ACCUM;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ACCUM: begin
          if (in_valid && in_ready) begin
            acc_q <= acc_sum_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNTW'(NUM - 1)) begin
              state_q  <= SHIFT;
              sh_cnt_q <= '0;
              in_ready <= 1'b0;
            end
          end
        end
        SHIFT: begin
          acc_q    <= acc_shift_d;
          sh_cnt_q <= sh_cnt_q + 1'b1;
          // The last shift edge also publishes the result from the shifted value.
          if (sh_cnt_q == SHW'(SHIFTS - 1)) begin
            avg       <= avg_d;
            avg_valid <= 1'b1;
            busy      <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: begin
          state_q  <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_avg8_seq_ctrl.sv
// tb_avg8_seq_ctrl: randomized self-checking bench against an arithmetic reference model.
`default_nettype none

module tb_avg8_seq_ctrl;

  localparam int SHIFTS = 3;

  logic        Clk;
  logic        Rst;
  logic        start;
  logic [7:0]  sa;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        busy;
  logic [15:0] avg;
  logic        avg_valid;

  int          n_tests;
  int          n_fail;
  logic [15:0] last_avg;
  logic [15:0] smp [8];

  avg8_seq_ctrl dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .start     (start),
    .sa        (sa),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .busy      (busy),
    .avg       (avg),
    .avg_valid (avg_valid)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: plain sum, SHIFTS logical shifts by sa, then width rule.
  function automatic logic [15:0] ref_avg(input logic [7:0] sa_v);
    logic [31:0] r;
    r = 32'd0;
    for (int i = 0; i < 8; i++) r = r + {16'd0, smp[i]};
    for (int k = 0; k < SHIFTS; k++) r = (sa_v >= 8'd32) ? 32'd0 : (r >> sa_v);
`ifdef AVG_SAT_EN
    return (r[31:16] != 16'd0) ? 16'hFFFF : r[15:0];
`else
    return r[15:0];
`endif
  endfunction

  // Ends in the avg_valid cycle so the caller may start the next op back-to-back.
  task automatic do_op(input logic [7:0] sa_v, input int gmax, input bit noisy);
    logic [15:0] exp;
    int          g;
    exp = ref_avg(sa_v);
    start = 1'b1;
    sa    = sa_v;
    tick();
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_rdy", in_ready, 1);
    check("vld_drop", avg_valid, 0);
    check("avg_hold", avg, last_avg);
    for (int i = 0; i < 8; i++) begin
      g = $urandom_range(gmax, 0);
      if (noisy && i == 3) begin
        g     = 1;
        start = 1'b1;
        sa    = 8'd1;
      end
      for (int j = 0; j < g; j++) begin
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        tick();
        start = 1'b0;
        check("gap_rdy", in_ready, 1);
        check("gap_busy", busy, 1);
      end
      in_valid = 1'b1;
      in_data  = smp[i];
      tick();
      in_valid = 1'b0;
      if (i < 7) check("acc_rdy", in_ready, 1);
    end
    check("shift_rdy", in_ready, 0);
    for (int k = 1; k <= SHIFTS; k++) begin
      if (noisy && k == 1) start = 1'b1;
      tick();
      start = 1'b0;
      if (k < SHIFTS) begin
        check("shift_vld", avg_valid, 0);
        check("shift_busy", busy, 1);
      end else begin
        check("res_vld", avg_valid, 1);
        check("res_avg", avg, exp);
        check("res_busy", busy, 0);
        check("res_rdy", in_ready, 0);
      end
    end
    last_avg = exp;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check("idle_vld", avg_valid, 0);
      check("idle_busy", busy, 0);
      check("idle_avg", avg, last_avg);
    end
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    last_avg = 16'd0;
    Rst      = 1'b0;
    start    = 1'b0;
    sa       = 8'd0;
    in_valid = 1'b0;
    in_data  = 16'd0;

    tick();
    tick();
    Rst = 1'b1;
    check("rst_avg", avg, 0);
    check("rst_vld", avg_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_rdy", in_ready, 0);
    idle(2);

    for (int i = 0; i < 8; i++) smp[i] = 16'd100;
    do_op(8'd1, 0, 1'b0);
    idle(1);

    for (int i = 0; i < 8; i++) smp[i] = 16'(i + 1);
    do_op(8'd1, 3, 1'b0);

    for (int i = 0; i < 8; i++) smp[i] = 16'hFFFF;
    do_op(8'd0, 0, 1'b0);
    idle(1);

    for (int i = 0; i < 8; i++) smp[i] = 16'($urandom);
    do_op(8'd40, 1, 1'b1);
    idle(1);

    for (int i = 0; i < 8; i++) smp[i] = 16'($urandom);
    do_op(8'd1, 2, 1'b1);

    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < 8; i++) smp[i] = 16'($urandom);
      do_op(8'($urandom_range(40, 0)), $urandom_range(3, 0), 1'($urandom));
      if ($urandom_range(1, 0) == 0) idle($urandom_range(2, 1));
    end

    for (int i = 0; i < 8; i++) smp[i] = 16'hABCD;
    do_op(8'd0, 0, 1'b0);
    start = 1'b1;
    sa    = 8'd2;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 16'd500;
      tick();
    end
    in_valid = 1'b0;
    Rst      = 1'b0;
    tick();
    Rst      = 1'b1;
    last_avg = 16'd0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rdy", in_ready, 0);
    check("mid_rst_vld", avg_valid, 0);
    check("mid_rst_avg", avg, 0);
    idle(5);

    for (int i = 0; i < 8; i++) smp[i] = 16'd8;
    do_op(8'd1, 1, 1'b0);
    check("final_avg8", avg, 16'd8);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
